memory_address_register: RTL and testbench

- Holds the CPU's current memory address. It is loaded from the datapath on a write strobe and drives the memory and bus address lines.
- Sits between the control unit/ALU result bus and the memory interface.
- Alongside the latched address, it provides registered status and decode flags: valid, misaligned and region select.

---
 rtl/memory_address_register.sv | 51 +++++
 tb/tb_memory_address_register.sv | 115 +++++++++++
 2 files changed

// File: rtl/memory_address_register.sv
// memory_address_register: latched CPU memory address with registered valid/alignment/region flags (option: MAR_INCREMENT_EN adds mar_inc)
module memory_address_register #(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VALUE = ADDR_WIDTH'(32'h0000_0000),
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE = ADDR_WIDTH'(32'h1000_0000),
    parameter logic [ADDR_WIDTH-1:0] IO_BASE = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mar_write,
`ifdef MAR_INCREMENT_EN
    input  logic                  mar_inc,
`endif
    input  logic [ADDR_WIDTH-1:0] address_in,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic                  addr_valid,
    output logic                  misaligned,
    output logic [1:0]            region_sel
);
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  load;

    function automatic logic [1:0] decode(input logic [ADDR_WIDTH-1:0] a);
        return (a >= IO_BASE) ? 2'b10 : (a >= RAM_BASE) ? 2'b01 : 2'b00;
    endfunction

    always_comb begin
`ifdef MAR_INCREMENT_EN
        next_addr = mar_write ? address_in : address_out + ADDR_WIDTH'(4);
        load = mar_write | mar_inc;
`else
        next_addr = address_in;
        load = mar_write;
`endif
    end

    // flags are derived from the value being loaded so they always track address_out
    always_ff @(posedge clk) begin
        if (reset) begin
            address_out <= RESET_VALUE;
            addr_valid <= 1'b0;
            misaligned <= |RESET_VALUE[1:0];
            region_sel <= decode(RESET_VALUE);
        end else if (load) begin
            address_out <= next_addr;
            addr_valid <= addr_valid | mar_write;
            misaligned <= |next_addr[1:0];
            region_sel <= decode(next_addr);
        end
    end
endmodule

// File: tb/tb_memory_address_register.sv
// tb_memory_address_register: directed scoreboard bench for memory_address_register
module tb_memory_address_register;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mar_write = 1'b0;
    logic [31:0] address_in = '0;
    logic [31:0] address_out;
    logic        addr_valid;
    logic        misaligned;
    logic [1:0]  region_sel;
`ifdef MAR_INCREMENT_EN
    logic        mar_inc = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic        v;
        logic        m;
        logic [1:0]  r;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    memory_address_register dut (
        .clk(clk),
        .reset(reset),
        .mar_write(mar_write),
`ifdef MAR_INCREMENT_EN
        .mar_inc(mar_inc),
`endif
        .address_in(address_in),
        .address_out(address_out),
        .addr_valid(addr_valid),
        .misaligned(misaligned),
        .region_sel(region_sel)
    );

    always #5 clk = ~clk;

    task automatic check();
        exp_t e;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard empty got %h want queued entry", address_out);
            return;
        end
        e = q.pop_front();
        assert (address_out === e.a) else begin
            miscompares++;
            $error("FAIL %s address_out got %h want %h", e.tag, address_out, e.a);
        end
        assert (addr_valid === e.v) else begin
            miscompares++;
            $error("FAIL %s addr_valid got %b want %b", e.tag, addr_valid, e.v);
        end
        assert (misaligned === e.m) else begin
            miscompares++;
            $error("FAIL %s misaligned got %b want %b", e.tag, misaligned, e.m);
        end
        assert (region_sel === e.r) else begin
            miscompares++;
            $error("FAIL %s region_sel got %b want %b", e.tag, region_sel, e.r);
        end
    endtask

    task automatic apply(input string tag, input logic rst, input logic wr, input logic [31:0] din,
                         input logic [31:0] ea, input logic ev, input logic em, input logic [1:0] er);
        @(negedge clk);
        reset = rst;
        mar_write = wr;
        address_in = din;
        q.push_back('{tag, ea, ev, em, er});
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        apply("reset0",    1, 0, 32'h0,        32'h0,        0, 0, 2'b00);
        apply("reset1",    1, 0, 32'h0,        32'h0,        0, 0, 2'b00);
        apply("released",  0, 0, 32'h0,        32'h0,        0, 0, 2'b00);
        apply("write_ram", 0, 1, 32'h12345678, 32'h12345678, 1, 0, 2'b01);
        apply("hold",      0, 0, 32'h87654321, 32'h12345678, 1, 0, 2'b01);
        apply("hold_x",    0, 0, 32'hxxxxxxxx, 32'h12345678, 1, 0, 2'b01);
        apply("write_io",  0, 1, 32'hAABBCCDD, 32'hAABBCCDD, 1, 1, 2'b10);
        apply("reset_mid", 1, 0, 32'h0,        32'h0,        0, 0, 2'b00);
        apply("rom_top",   0, 1, 32'h0FFFFFFC, 32'h0FFFFFFC, 1, 0, 2'b00);
        apply("rst_wins",  1, 1, 32'hFFFFFFFF, 32'h0,        0, 0, 2'b00);
        apply("ram_base",  0, 1, 32'h10000000, 32'h10000000, 1, 0, 2'b01);
        apply("ram_top",   0, 1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 1, 2'b01);
        apply("io_base",   0, 1, 32'h80000000, 32'h80000000, 1, 0, 2'b10);
        apply("all_ones",  0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 2'b10);
        apply("rom_odd",   0, 1, 32'h0FFFFFFF, 32'h0FFFFFFF, 1, 1, 2'b00);
        apply("hold_rom",  0, 0, 32'h55555555, 32'h0FFFFFFF, 1, 1, 2'b00);
`ifdef MAR_INCREMENT_EN
        apply("pre_wrap",  0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 2'b10);
        mar_inc = 1'b1;
        apply("inc_wrap",  0, 0, 32'h0,        32'h0,        1, 0, 2'b00);
        apply("write_win", 0, 1, 32'h00000100, 32'h00000100, 1, 0, 2'b00);
        apply("inc",       0, 0, 32'h0,        32'h00000104, 1, 0, 2'b00);
        apply("rst_inc",   1, 0, 32'h0,        32'h0,        0, 0, 2'b00);
        mar_inc = 1'b0;
`endif
        if (q.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard leftover got %0d want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
